// File: rtl/ring_pkg.sv
// Shared definitions for ring counter consumers: ring geometry, position index
// width and the decoder's tracking state.
package ring_pkg;

    localparam int STRIDE    = 3;
    localparam int POSITIONS = 5;
    localparam int RING_W    = STRIDE * POSITIONS;
    localparam int POS_W     = (POSITIONS > 1) ? $clog2(POSITIONS) : 1;

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } state_t;

endpackage

// File: rtl/ring_position_decoder_if.sv
// Bundle between a ring observer (slave) and its consumer/stimulus (master):
// the sampled ring, its enable, error clear and all decoder status outputs.
interface ring_position_decoder_if
    import ring_pkg::*;
#(
    parameter int ERR_CNT_W = 8
);
    logic [RING_W-1:0]    ring;
    logic                 en;
    logic                 clr_err;
    logic [POS_W-1:0]     pos;
    logic                 pos_valid;
    logic                 wrap;
    logic                 locked;
    logic                 illegal_err;
    logic                 seq_err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 stall;

    modport master (
        output ring, en, clr_err,
        input  pos, pos_valid, wrap, locked, illegal_err, seq_err, err_cnt, stall
    );

    modport slave (
        input  ring, en, clr_err,
        output pos, pos_valid, wrap, locked, illegal_err, seq_err, err_cnt, stall
    );
endinterface

// File: rtl/ring_onehot_decode.sv
// Combinational strided one-hot decoder: legal when exactly one bit is set and
// it sits on a stride boundary; index is that bit's position number.
module ring_onehot_decode
    import ring_pkg::*;
(
    input  logic [RING_W-1:0] ring,
    output logic              legal,
    output logic [POS_W-1:0]  index
);
    logic [POSITIONS-1:0]            hits;
    logic [POS_W-1:0][POSITIONS-1:0] sel;

    for (genvar g = 0; g < POSITIONS; g++) begin : g_hit
        assign hits[g] = ring[g*STRIDE];
    end

    // Index bit b is the OR of every on-stride bit whose position has bit b set.
    for (genvar b = 0; b < POS_W; b++) begin : g_bit
        for (genvar g = 0; g < POSITIONS; g++) begin : g_pos
            assign sel[b][g] = (((g >> b) & 1) != 0) ? hits[g] : 1'b0;
        end
        assign index[b] = |sel[b];
    end

    assign legal = ($countones(ring) == 1) && ($countones(hits) == 1);
endmodule

// File: rtl/ring_position_decoder.sv
// Ring position decoder: decodes, sequence-checks and lock-tracks a strided
// one-hot ring. Define RING_STALL_EN to add the locked-but-stationary timeout.
//
//  state  | meaning
//  SEARCH | no legal history; illegal samples are ignored silently
//  TRACK  | legal history, counting correct transitions toward lock
//  LOCKED | LOCK_CNT consecutive correct transitions seen
module ring_position_decoder
    import ring_pkg::*;
#(
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8
`ifdef RING_STALL_EN
    ,
    parameter int STALL_CYCLES = 1024
`endif
) (
    input logic                 clk,
    input logic                 rst_n,
    ring_position_decoder_if.slave bus
);
    localparam int               GOOD_W   = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(POSITIONS - 1);

    logic                 dec_legal;
    logic [POS_W-1:0]     dec_idx;
    state_t               state_q, state_d;
    logic [GOOD_W-1:0]    good_q, good_d;
    logic [POS_W-1:0]     pos_q, pos_d, exp_idx;
    logic                 valid_q, en_q;
    logic                 wrap_q, wrap_d, ill_q, ill_d, seq_q, seq_d;
    logic                 good_tr, bad_tr;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    ring_onehot_decode u_decode (
        .ring  (bus.ring),
        .legal (dec_legal),
        .index (dec_idx)
    );

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        pos_d   = dec_legal ? dec_idx : pos_q;
        ill_d   = 1'b0;
        exp_idx = en_q ? ((pos_q == LAST_POS) ? '0 : pos_q + 1'b1) : pos_q;
        // valid_q doubles as "history present": it is clear after reset and after any illegal sample.
        good_tr = dec_legal && valid_q && (dec_idx == exp_idx);
        bad_tr  = dec_legal && valid_q && (dec_idx != exp_idx);
        seq_d   = bad_tr;
        wrap_d  = good_tr && en_q && (pos_q == LAST_POS);
        case (state_q)
            SEARCH: begin
                if (dec_legal) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK: begin
                if (!dec_legal) begin
                    state_d = SEARCH;
                    ill_d   = 1'b1;
                end else if (bad_tr) begin
                    good_d = '0;
                end else if (good_tr) begin
                    good_d = good_q + 1'b1;
                    if (good_q == GOOD_W'(LOCK_CNT - 1)) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!dec_legal) begin
                    state_d = SEARCH;
                    ill_d   = 1'b1;
                end else if (bad_tr) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
        err_d = err_q;
        if (bus.clr_err)                         err_d = '0;
        else if ((ill_d || bad_tr) && err_q != '1) err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            good_q  <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            wrap_q  <= 1'b0;
            ill_q   <= 1'b0;
            seq_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            pos_q   <= pos_d;
            valid_q <= dec_legal;
            en_q    <= bus.en;
            wrap_q  <= wrap_d;
            ill_q   <= ill_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
        end
    end

`ifdef RING_STALL_EN
    localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    logic [STALL_W-1:0] stall_tmr_q, stall_tmr_d;
    logic               stall_q, stall_d, held;

    // Down-counter reloads whenever the ring moves or lock is lost; terminal count fires the pulse.
    always_comb begin
        held        = (state_q == LOCKED) && (state_d == LOCKED) && (dec_idx == pos_q);
        stall_d     = 1'b0;
        stall_tmr_d = STALL_W'(STALL_CYCLES - 1);
        if (held) begin
            if (stall_tmr_q == '0) stall_d = 1'b1;
            else                   stall_tmr_d = stall_tmr_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_tmr_q <= STALL_W'(STALL_CYCLES - 1);
            stall_q     <= 1'b0;
        end else begin
            stall_tmr_q <= stall_tmr_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.stall = stall_q;
`else
    assign bus.stall = 1'b0;
`endif

    assign bus.pos         = pos_q;
    assign bus.pos_valid   = valid_q;
    assign bus.wrap        = wrap_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.illegal_err = ill_q;
    assign bus.seq_err     = seq_q;
    assign bus.err_cnt     = err_q;
endmodule

// File: tb/tb_ring_position_decoder.sv
// Self-checking bench for ring_position_decoder: directed scenarios plus random
// ring traffic, compared every cycle against a behavioural model.
module tb_ring_position_decoder;
    localparam int LOCK      = 2;
    localparam int STALL_LEN = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   cmp_on  = 1'b0;

    ring_position_decoder_if #(.ERR_CNT_W(8)) bus ();

`ifdef RING_STALL_EN
    ring_position_decoder #(.LOCK_CNT(LOCK), .ERR_CNT_W(8), .STALL_CYCLES(STALL_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`else
    ring_position_decoder #(.LOCK_CNT(LOCK), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = search, 1 = track, 2 = locked.
    int m_pos = 0, m_valid = 0, m_wrap = 0, m_ill = 0, m_seq = 0, m_err = 0, m_stall = 0;
    int m_mode = 0, m_good = 0, m_prev_en = 0, m_hold = 0;

    always @(posedge clk) begin
        int cnt, idx, p, want, old_mode, ev;
        bit legal, held;
        if (!rst_n) begin
            m_pos = 0; m_valid = 0; m_wrap = 0; m_ill = 0; m_seq = 0; m_err = 0;
            m_stall = 0; m_mode = 0; m_good = 0; m_prev_en = 0; m_hold = 0;
        end else begin
            cnt = 0; idx = 0;
            for (int i = 0; i < 15; i++) if (bus.ring[i]) begin cnt++; idx = i; end
            legal = (cnt == 1) && (idx % 3 == 0);
            p = idx / 3;
            m_wrap = 0; m_ill = 0; m_seq = 0; ev = 0; held = 0;
            old_mode = m_mode;
            if (!legal) begin
                if (m_mode != 0) begin m_ill = 1; ev = 1; end
                m_mode = 0;
                m_valid = 0;
            end else begin
                if (m_valid != 0) begin
                    want = (m_prev_en != 0) ? (m_pos + 1) % 5 : m_pos;
                    if (p == want) begin
                        if (m_prev_en != 0 && m_pos == 4) m_wrap = 1;
                        if (m_mode == 1) begin
                            m_good++;
                            if (m_good >= LOCK) m_mode = 2;
                        end
                    end else begin
                        m_seq = 1; ev = 1; m_good = 0; m_mode = 1;
                    end
                end else begin
                    m_mode = 1; m_good = 0;
                end
                held = (old_mode == 2) && (m_mode == 2) && (p == m_pos);
                m_pos = p;
                m_valid = 1;
            end
            if (bus.clr_err) m_err = 0;
            else if (ev != 0 && m_err < 255) m_err++;
            m_stall = 0;
`ifdef RING_STALL_EN
            if (held) begin
                m_hold++;
                if (m_hold == STALL_LEN) begin m_stall = 1; m_hold = 0; end
            end else m_hold = 0;
`else
            if (held) m_hold++;
`endif
            m_prev_en = bus.en ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("pos", bus.pos, m_pos);
            chk("pos_valid", bus.pos_valid, m_valid);
            chk("wrap", bus.wrap, m_wrap);
            chk("locked", bus.locked, (m_mode == 2) ? 1 : 0);
            chk("illegal_err", bus.illegal_err, m_ill);
            chk("seq_err", bus.seq_err, m_seq);
            chk("err_cnt", bus.err_cnt, m_err);
            chk("stall", bus.stall, m_stall);
        end
    end

    function automatic logic [14:0] onehot(input int p);
        logic [14:0] v;
        v = '0;
        v[p*3] = 1'b1;
        return v;
    endfunction

    // Apply one sample at a negedge and return at the next negedge, when the outputs show it.
    task automatic cyc(input logic [14:0] r, input logic e, input logic c);
        bus.ring = r;
        bus.en = e;
        bus.clr_err = c;
        @(negedge clk);
    endtask

    initial begin
        int wraps, stalls, cur, drv_pos, r;
        logic drv_en;
        rst_n = 1'b0;
        bus.ring = '0; bus.en = 1'b0; bus.clr_err = 1'b0;
        @(negedge clk);
        cyc(15'h0000, 1'b0, 1'b0);
        cmp_on = 1'b1;
        chk("reset_pos", bus.pos, 0);
        chk("reset_valid", bus.pos_valid, 0);
        chk("reset_locked", bus.locked, 0);
        rst_n = 1'b1;

        cyc(15'h0001, 1'b0, 1'b0);
        chk("acq_valid", bus.pos_valid, 1);
        chk("acq_locked0", bus.locked, 0);
        cyc(15'h0001, 1'b0, 1'b0);
        chk("acq_locked1", bus.locked, 0);
        cyc(15'h0001, 1'b0, 1'b0);
        chk("acq_locked2", bus.locked, 1);
        chk("acq_err", bus.err_cnt, 0);

        wraps = 0;
        cyc(15'h0001, 1'b1, 1'b0); wraps += bus.wrap;
        cyc(15'h0008, 1'b1, 1'b0); wraps += bus.wrap;
        chk("walk_pos1", bus.pos, 1);
        cyc(15'h0040, 1'b1, 1'b0); wraps += bus.wrap;
        cyc(15'h0200, 1'b1, 1'b0); wraps += bus.wrap;
        cyc(15'h1000, 1'b1, 1'b0); wraps += bus.wrap;
        chk("walk_pos4", bus.pos, 4);
        cyc(15'h0001, 1'b1, 1'b0); wraps += bus.wrap;
        chk("walk_wraps", wraps, 1);
        chk("walk_pos0", bus.pos, 0);

        cyc(15'h0008, 1'b1, 1'b0);
        cyc(15'h0200, 1'b1, 1'b0);
        chk("skip_seq", bus.seq_err, 1);
        chk("skip_err", bus.err_cnt, 1);
        chk("skip_locked", bus.locked, 0);
        cyc(15'h1000, 1'b1, 1'b0);
        cyc(15'h0001, 1'b1, 1'b0);
        chk("relock", bus.locked, 1);

        cyc(15'h0002, 1'b0, 1'b0);
        chk("offstride_ill", bus.illegal_err, 1);
        chk("offstride_err", bus.err_cnt, 2);
        chk("offstride_pos", bus.pos, 0);
        cyc(15'h0009, 1'b0, 1'b0);
        chk("search_ill", bus.illegal_err, 0);
        chk("search_err", bus.err_cnt, 2);

        cyc(15'h0001, 1'b0, 1'b0);
        cur = 0;
        for (int k = 0; k < 260; k++) begin
            cur = (cur + 1) % 5;
            cyc(onehot(cur), 1'b0, 1'b0);
        end
        chk("sat_err", bus.err_cnt, 255);
        cur = (cur + 1) % 5;
        cyc(onehot(cur), 1'b0, 1'b0);
        chk("sat_hold", bus.err_cnt, 255);
        cur = (cur + 1) % 5;
        cyc(onehot(cur), 1'b0, 1'b1);
        chk("clr_seq", bus.seq_err, 1);
        chk("clr_err", bus.err_cnt, 0);

        stalls = 0;
        for (int k = 0; k < 22; k++) begin
            cyc(onehot(cur), 1'b0, 1'b0);
            stalls += bus.stall;
        end
        chk("hold_locked", bus.locked, 1);
`ifdef RING_STALL_EN
        chk("stall_pulses", stalls, 2);
`else
        chk("stall_pulses", stalls, 0);
`endif

        rst_n = 1'b0;
        cyc(15'h0001, 1'b1, 1'b0);
        chk("midrst_valid", bus.pos_valid, 0);
        chk("midrst_pos", bus.pos, 0);
        chk("midrst_locked", bus.locked, 0);
        rst_n = 1'b1;
        cyc(15'h0008, 1'b0, 1'b0);
        chk("post_rst_seq", bus.seq_err, 0);
        chk("post_rst_pos", bus.pos, 1);

        drv_pos = 1; drv_en = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                if (drv_en) drv_pos = (drv_pos + 1) % 5;
                bus.ring = onehot(drv_pos);
            end else if (r < 80) begin
                drv_pos = $urandom_range(0, 4);
                bus.ring = onehot(drv_pos);
            end else if (r < 90) begin
                bus.ring = 15'($urandom);
            end else if (r < 93) begin
                bus.ring = '0;
            end else begin
                bus.ring = onehot(drv_pos);
            end
            drv_en = ($urandom_range(0, 2) != 0);
            bus.en = drv_en;
            bus.clr_err = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
